// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR with zero-state recovery, mode-change
// resynchronisation and measurement of the sequence period.
module lfsr_gen #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h0000_008E,
    parameter logic [31:0] SEED  = 32'h0000_00BD,
    parameter int unsigned STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] TAP_W  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

    logic [WIDTH-1:0] state_q,  state_d;
    logic [WIDTH-1:0] start_q,  start_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q,   wrap_d;
    logic             lockup_q, lockup_d;
    logic             mode_q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] cnt_inc;

    // STEPS single shifts chained combinationally within one cycle
    always_comb begin
        nxt = state_q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            if (mode) begin
                nxt = {nxt[WIDTH-2:0], 1'b0} ^ (nxt[WIDTH-1] ? TAP_W : '0);
            end else begin
                nxt = {nxt[WIDTH-2:0], ^(nxt & TAP_W)};
            end
        end
    end

    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            state_d = (seed_in != '0) ? seed_in : SEED_W;
            start_d = (seed_in != '0) ? seed_in : SEED_W;
            cnt_d   = '0;
        end else if (mode != mode_q) begin
            // A rule change restarts the period measurement from here
            start_d = state_q;
            cnt_d   = '0;
        end else if (en) begin
            if (state_q == '0) begin
                state_d  = SEED_W;
                start_d  = SEED_W;
                cnt_d    = '0;
                lockup_d = 1'b1;
            end else begin
                state_d = nxt;
                if (nxt == start_q) begin
                    wrap_d   = 1'b1;
                    period_d = cnt_inc;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEED_W;
            start_q  <= SEED_W;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
            mode_q   <= mode;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
            mode_q   <= mode;
        end
    end

    assign out    = state_q;
    assign wrap   = wrap_q;
    assign period = period_q;
    assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three configurations checked every cycle against a
// behavioural model, plus directed checks of the known start-up sequences.
module tb_lfsr_gen;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, mode, load;
    logic [7:0] seed_in;
    logic [3:0] seed4;

    logic [7:0] out8, per8, out3, per3;
    logic [3:0] out4, per4;
    logic       wrap8, lock8, wrap3, lock3, wrap4, lock4;

    lfsr_gen u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .seed_in(seed_in), .out(out8), .wrap(wrap8), .period(per8), .lockup(lock8)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(32'h8E), .SEED(32'hBD), .STEPS(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .seed_in(seed_in), .out(out3), .wrap(wrap3), .period(per3), .lockup(lock3)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(32'h1), .SEED(32'h9), .STEPS(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .seed_in(seed4), .out(out4), .wrap(wrap4), .period(per4), .lockup(lock4)
    );

    int          W   [NI] = '{8, 8, 4};
    int          STP [NI] = '{1, 3, 1};
    logic [31:0] TP  [NI] = '{32'h8E, 32'h8E, 32'h1};
    logic [31:0] SD  [NI] = '{32'hBD, 32'hBD, 32'h9};

    typedef struct {
        logic [31:0] st, start, cnt, period;
        logic        wrap, lock, mq;
    } mdl_t;
    mdl_t m [NI];

    logic [31:0] o_out [NI];
    logic [31:0] o_per [NI];
    logic        o_wrap [NI];
    logic        o_lock [NI];
    assign o_out[0] = 32'(out8);  assign o_per[0] = 32'(per8);
    assign o_out[1] = 32'(out3);  assign o_per[1] = 32'(per3);
    assign o_out[2] = 32'(out4);  assign o_per[2] = 32'(per4);
    assign o_wrap[0] = wrap8; assign o_lock[0] = lock8;
    assign o_wrap[1] = wrap3; assign o_lock[1] = lock3;
    assign o_wrap[2] = wrap4; assign o_lock[2] = lock4;

    int unsigned total = 0;
    int unsigned bad   = 0;
    string       phase = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int k);
        return (32'h1 << W[k]) - 32'h1;
    endfunction

    // Advance by one enabled cycle: STP[k] shifts, written as integer arithmetic
    function automatic logic [31:0] adv(input int k, input logic [31:0] s, input logic md);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < STP[k]; i++) begin
            if (!md) r = ((r << 1) | 32'($countones(r & TP[k]) % 2)) & mask_of(k);
            else     r = ((r << 1) & mask_of(k)) ^ (r[W[k]-1] ? TP[k] : 32'h0);
        end
        return r;
    endfunction

    function automatic int ref_period(input int k, input logic [31:0] s0, input logic md);
        logic [31:0] s;
        int n;
        s = s0;
        n = 0;
        do begin
            s = adv(k, s, md);
            n++;
        end while (s != s0 && n < 1000);
        return n;
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < NI; k++) begin
            m[k].st = SD[k]; m[k].start = SD[k]; m[k].cnt = '0; m[k].period = '0;
            m[k].wrap = 1'b0; m[k].lock = 1'b0; m[k].mq = mode;
        end
    endtask

    task automatic mdl_step();
        logic [31:0] sd, n, msk;
        for (int k = 0; k < NI; k++) begin
            msk = mask_of(k);
            sd  = ((k == 2) ? 32'(seed4) : 32'(seed_in)) & msk;
            m[k].wrap = 1'b0;
            m[k].lock = 1'b0;
            if (load) begin
                m[k].st    = (sd != 0) ? sd : SD[k];
                m[k].start = m[k].st;
                m[k].cnt   = '0;
            end else if (mode != m[k].mq) begin
                m[k].start = m[k].st;
                m[k].cnt   = '0;
            end else if (en) begin
                if (m[k].st == 0) begin
                    m[k].st = SD[k]; m[k].start = SD[k]; m[k].cnt = '0; m[k].lock = 1'b1;
                end else begin
                    n = adv(k, m[k].st, mode);
                    m[k].cnt = (m[k].cnt + 1) & msk;
                    if (n == m[k].start) begin
                        m[k].wrap = 1'b1; m[k].period = m[k].cnt; m[k].cnt = '0;
                    end
                    m[k].st = n;
                end
            end
            m[k].mq = mode;
        end
    endtask

    task automatic chk_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s.out%0d", phase, k),  o_out[k],         m[k].st);
            chk($sformatf("%s.per%0d", phase, k),  o_per[k],         m[k].period);
            chk($sformatf("%s.wrap%0d", phase, k), 32'(o_wrap[k]),   32'(m[k].wrap));
            chk($sformatf("%s.lock%0d", phase, k), 32'(o_lock[k]),   32'(m[k].lock));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) mdl_step();
        else       mdl_reset();
        chk_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mdl_reset();
        chk_all();
        tick();
        rst_n = 1'b1;
    endtask

    int          P, nw, first, second;
    logic [31:0] prev;
    logic [7:0]  pper;

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; seed_in = '0; seed4 = '0;
        #2;
        phase = "reset";
        do_reset();
        chk("rst_out", 32'(out8), 32'hBD);
        chk("rst_per", 32'(per8), 32'h0);
        chk("rst_wrap", 32'(wrap8), 32'h0);
        chk("rst_lock", 32'(lock8), 32'h0);

        phase = "fib";
        en = 1'b1;
        chk("fib0", 32'(out8), 32'hBD);
        tick(); chk("fib1", 32'(out8), 32'h7B);
        tick(); chk("fib2", 32'(out8), 32'hF6);

        phase = "gal";
        en = 1'b0; mode = 1'b1;
        do_reset();
        en = 1'b1;
        chk("gal0", 32'(out8), 32'hBD);
        tick(); chk("gal1", 32'(out8), 32'hF4);

        phase = "cycle";
        en = 1'b0; mode = 1'b0;
        do_reset();
        P = ref_period(0, 32'hBD, 1'b0);
        nw = 0; first = -1; second = -1;
        en = 1'b1;
        for (int c = 0; c < 2 * P + 2; c++) begin
            tick();
            if (wrap8) begin
                nw++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        chk("wrap_count", 32'(nw), 32'd2);
        chk("wrap_first", 32'(first), 32'(P - 1));
        chk("wrap_gap", 32'(second - first), 32'(P));
        chk("period_rpt", 32'(per8), 32'(P & 255));

        phase = "ld0";
        en = 1'b0; load = 1'b1; seed_in = 8'h00; seed4 = 4'h0;
        tick();
        chk("ld0_out", 32'(out8), 32'hBD);
        chk("ld0_lock", 32'(lock8), 32'h0);

        phase = "ld55";
        pper = per8;
        en = 1'b1; seed_in = 8'h55;
        tick();
        chk("ld55_out", 32'(out8), 32'h55);
        chk("ld55_per", 32'(per8), 32'(pper));

        phase = "w4";
        en = 1'b0; seed4 = 4'h8; seed_in = 8'h01;
        tick();
        load = 1'b0; en = 1'b1;
        chk("w4_a", 32'(out4), 32'h8);
        tick(); chk("w4_zero", 32'(out4), 32'h0); chk("w4_nolock", 32'(lock4), 32'h0);
        tick(); chk("w4_seed", 32'(out4), 32'h9); chk("w4_lock", 32'(lock4), 32'h1);
        tick(); chk("w4_lock1", 32'(lock4), 32'h0);

        phase = "mtog";
        prev = 32'(out8);
        mode = 1'b1;
        tick(); chk("mt_hold", 32'(out8), prev);
        tick(); chk("mt_resume", 32'(out8), adv(0, prev, 1'b1));

        phase = "rand";
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            mode    = ($urandom_range(0, 15) == 0) ? ~mode : mode;
            load    = ($urandom_range(0, 24) == 0);
            seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            seed4   = 4'($urandom);
            tick();
        end

        phase = "arst";
        load = 1'b0; en = 1'b1; mode = 1'b0;
        tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out8), 32'hBD);
        chk("arst_wrap", 32'(wrap8), 32'h0);
        chk("arst_lock", 32'(lock8), 32'h0);
        mdl_reset();
        chk_all();
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_adv", 32'(out8), 32'h7B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
